// File: rtl/timer_bank_if.sv
// timer_bank bus control bundle: address, strobe, direction.
// Data stays a plain inout port on the block.
interface timer_bank_if #(
  parameter int CH_BITS = 1
);
  logic [CH_BITS+1:0] busAddr;
  logic               busEn;
  logic               busWr;

  modport master (output busAddr, busEn, busWr);
  modport slave  (input  busAddr, busEn, busWr);
endinterface

// File: rtl/timer_bank.sv
// timer_bank: 2^CH_BITS bus-mapped up-counters with OR'd interrupt.
// Optional prescaler: define TIMER_BANK_PRESCALE_EN.
module timer_bank #(
  parameter int WIDTH   = 16,
  parameter int CH_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  timer_bank_if.slave      bus,
  inout  wire  [WIDTH-1:0] busData,
  input  logic             clk2,
  output logic             sigIntr
);
  localparam int NCH = 1 << CH_BITS;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_t;

  st_t              st_q   [NCH];
  st_t              st_d   [NCH];
  logic [WIDTH-1:0] cnt_q  [NCH];
  logic [WIDTH-1:0] cnt_d  [NCH];
  logic [WIDTH-1:0] max_q  [NCH];
  logic [WIDTH-1:0] max_d  [NCH];
  logic [NCH-1:0]   auto_q, auto_d;
  logic [NCH-1:0]   src_q, src_d;
  logic [NCH-1:0]   ie_q, ie_d;
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [NCH-1:0]   tick_c, set_c, hit_c;
`ifdef TIMER_BANK_PRESCALE_EN
  logic [3:0]       pre_q  [NCH];
  logic [3:0]       pre_d  [NCH];
  logic [3:0]       psc_q  [NCH];
  logic [3:0]       psc_d  [NCH];
`endif
  logic [2:0]       sync_q;
  logic             ev2;
  logic             wr;
  logic [CH_BITS-1:0] ch_sel;
  logic [1:0]       reg_sel;
  logic [WIDTH-1:0] rdata;

  assign ev2     = sync_q[1] & ~sync_q[2];
  assign wr      = bus.busEn & bus.busWr;
  assign ch_sel  = bus.busAddr[CH_BITS+1:2];
  assign reg_sel = bus.busAddr[1:0];

  // Shared clk2 synchroniser plus edge-detect register.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], clk2};
  end

  // Next state per channel: tick first, then bus write overrides, OVF set last.
  always_comb begin
    auto_d = auto_q;
    src_d  = src_q;
    ie_d   = ie_q;
    ovf_d  = ovf_q;
    tick_c = '0;
    set_c  = '0;
    hit_c  = '0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      max_d[i] = max_q[i];
      tick_c[i] = (st_q[i] == RUN) & (src_q[i] ? ev2 : 1'b1);
`ifdef TIMER_BANK_PRESCALE_EN
      pre_d[i] = pre_q[i];
      psc_d[i] = psc_q[i];
      if (tick_c[i]) begin
        if (psc_q[i] == pre_q[i]) begin
          psc_d[i] = 4'd0;
        end else begin
          psc_d[i]  = psc_q[i] + 4'd1;
          tick_c[i] = 1'b0;
        end
      end
`endif
      if (tick_c[i]) begin
        if (cnt_q[i] == max_q[i]) begin
          set_c[i] = 1'b1;
          if (auto_q[i]) cnt_d[i] = '0;
          else           st_d[i]  = IDLE;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      hit_c[i] = wr & (ch_sel == CH_BITS'(i));
      if (hit_c[i]) begin
        unique case (reg_sel)
          2'd0: begin
            st_d[i]   = busData[0] ? RUN : IDLE;
            auto_d[i] = busData[1];
            src_d[i]  = busData[2];
            ie_d[i]   = busData[3];
`ifdef TIMER_BANK_PRESCALE_EN
            pre_d[i]  = busData[7:4];
            psc_d[i]  = 4'd0;
`endif
          end
          2'd1: cnt_d[i] = busData;
          2'd2: max_d[i] = busData;
          2'd3: if (busData[0]) ovf_d[i] = 1'b0;
        endcase
      end
      if (set_c[i]) ovf_d[i] = 1'b1;
    end
  end

  // Channel register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_q <= '0;
      src_q  <= '0;
      ie_q   <= '0;
      ovf_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        max_q[i] <= '0;
`ifdef TIMER_BANK_PRESCALE_EN
        pre_q[i] <= '0;
        psc_q[i] <= '0;
`endif
      end
    end else begin
      auto_q <= auto_d;
      src_q  <= src_d;
      ie_q   <= ie_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        max_q[i] <= max_d[i];
`ifdef TIMER_BANK_PRESCALE_EN
        pre_q[i] <= pre_d[i];
        psc_q[i] <= psc_d[i];
`endif
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      2'd0: begin
        rdata[3:0] = {ie_q[ch_sel], src_q[ch_sel],
                      auto_q[ch_sel], st_q[ch_sel] == RUN};
`ifdef TIMER_BANK_PRESCALE_EN
        rdata[7:4] = pre_q[ch_sel];
`endif
      end
      2'd1: rdata = cnt_q[ch_sel];
      2'd2: rdata = max_q[ch_sel];
      2'd3: rdata[0] = ovf_q[ch_sel];
    endcase
  end

  assign busData = (bus.busEn && !bus.busWr) ? rdata : 'z;
  assign sigIntr = |(ovf_q & ie_q);

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel bus-mapped timer; successor to the single 16-bit timer. It provides 2^CH_BITS independent up-counters of WIDTH bits. Each counter has one-shot or auto-reload mode, a selectable tick source (`clk` or synchronised `clk2` rising edges) and a sticky overflow flag. The block sits on the shared tristate data bus as a peripheral and drives a single OR-combined interrupt line.

## Interface
- `WIDTH`, 16: counter, compare and bus data width; legal range 8..32.
- `CH_BITS`, 1: log2 of the channel count; channels = 2^CH_BITS.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `busAddr`  in  CH_BITS+2: `[CH_BITS+1:2]` selects the channel; `[1:0]` selects the register.
- `busData`  inout  WIDTH: bidirectional data; the block drives it only during a read.
- `busEn`  in  1: bus access strobe.
- `busWr`  in  1: 1 = write, 0 = read; meaningful only when `busEn=1`.
- `clk2`  in  1: asynchronous external tick source.
- `sigIntr`  out  1: OR over channels of (OVF & IE).

## Operation
- Per-channel registers, selected by `busAddr[1:0]`:
  - 0 CTRL: bit0 EN, bit1 AUTO, bit2 SRC (0=`clk`, 1=`clk2` edge), bit3 IE, bits[7:4] PRE (macro only); other bits read 0.
  - 1 COUNT: current count.
  - 2 MAX: terminal value.
  - 3 STATUS: bit0 OVF; write 1 clears it, write 0 has no effect.
- Read (`busEn=1`, `busWr=0`): `busData` is driven combinationally with the selected register in the same cycle. Otherwise `busData` is high-Z.
- Write (`busEn=1`, `busWr=1`): the selected register is loaded from `busData` at the next `clk` edge.
- Source event:
  - SRC=0: every cycle.
  - SRC=1: rising edge of `clk2` after a 2-flop synchroniser and edge detect. One shared synchroniser serves all channels.
- Tick = source event while EN=1, gated by the prescaler when the macro is compiled in.
- On a tick:
  - COUNT≠MAX: COUNT+1.
  - COUNT==MAX: OVF←1. If AUTO=1, COUNT←0. If AUTO=0, COUNT holds and EN←0 (one-shot).
- MAX=0: every tick overflows.
- COUNT>MAX, e.g. after a software write: increments modulo 2^WIDTH until it reaches MAX.
- Per-channel state machine:
  - IDLE (EN=0) → RUN on a write with EN=1.
  - RUN → IDLE on a one-shot terminal tick or a write with EN=0.
  - RUN → RUN on an auto-reload terminal tick.
- Simultaneous events, same channel, same cycle:
  - COUNT write vs tick: the write wins.
  - CTRL write vs one-shot EN clear: the written EN wins.
  - STATUS clear vs new overflow: set wins, so OVF=1.
- Channels are fully independent; a write to one channel never disturbs another.

## Timing
- Reset values: all CTRL/COUNT/MAX/STATUS = 0, prescaler counters = 0, synchroniser flops = 0, `sigIntr`=0, `busData` high-Z unless a read is in progress.
- Reset mid-count clears everything in the same edge. No tick occurs on the reset edge.
- Write→effect: a register written at edge N is visible on reads and in the count from cycle N+1.
- SRC=0 with EN written at edge N: the first increment occurs at edge N+1.
- `clk2` rising → tick: 3 `clk` edges (2 sync + 1 edge-detect register).
- `clk2` pulses shorter than 2 `clk` periods may be missed.
- OVF set at edge N → `sigIntr` high in cycle N+1 onward (combinational from registers).
- Read latency 0; no wait states.

## Configuration
- `TIMER_BANK_PRESCALE_EN` defined:
  - CTRL[7:4] PRE is implemented, with a 4-bit prescale counter per channel.
  - A tick fires on every (PRE+1)th source event; PRE=0 is the same as no prescaling.
  - The prescale counter clears on any CTRL write and on reset.
- Undefined: PRE is not stored and reads 0; every source event is a tick.

## Test plan
- Reset, then read each register of channels 0 and 1 → all read 0; `busData` high-Z with `busEn=0`; `sigIntr`=0.
- Ch0: MAX=3, CTRL=0x0B (EN, AUTO, IE), SRC=`clk` → COUNT sequence 1,2,3,0,1…; OVF set and `sigIntr`=1 one cycle after the first 3→0 wrap.
- Ch1: MAX=2, CTRL=0x01 (one-shot) → COUNT 1,2 then holds at 2; EN reads 0; OVF=1; `sigIntr` stays 0 because IE=0. Ch0 is unaffected throughout.
- Ch0: SRC=1, EN=1; pulse `clk2` high 4 cycles, 5 times → COUNT=5. Each increment lands 3 edges after the corresponding `clk2` rise.
- Write STATUS=1 on the same cycle ch0 wraps → OVF stays 1. Write STATUS=1 on a quiet cycle → OVF=0 and `sigIntr` falls next cycle.
- With `TIMER_BANK_PRESCALE_EN`: CTRL=0x23 (PRE=2, EN, AUTO) → COUNT increments every 3rd cycle. Assert `rst` mid-count → all registers read 0 on the next cycle.
